// File: rtl/mlp_ox_sequencer.sv
// Hardware driver for mlp_OX. It evaluates the test set, trains for EPOCHS epochs,
// then evaluates the test set again, counting passes before and after training.
module mlp_ox_sequencer #(
  parameter int NTRAIN = 100,
  parameter int NTEST  = 10,
  parameter int EPOCHS = 10,
  parameter int IW     = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [IW+1:0] pat_addr,
  input  logic [15:0]   pat_data,
  output logic [15:0]   mlp_x,
  output logic          mlp_is_O,
  output logic          mlp_learn,
  input  logic          mlp_y,
  output logic          busy,
  output logic          done,
  output logic [1:0]    phase,
  output logic [7:0]    epoch_cnt,
  output logic [7:0]    pre_pass,
  output logic [7:0]    post_pass
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_SAMPLE, S_UPD, S_GAP, S_DONE
  } state_t;

  state_t        state, state_n;
  logic          is_test, is_test_n;
  logic          label, label_n;
  logic [IW-1:0] idx, idx_n;
  logic [1:0]    wait_cnt, wait_n;
  logic [1:0]    phase_n;
  logic [7:0]    epoch_n, pre_n, post_n;
  logic [15:0]   mlp_x_n;
  logic          mlp_is_O_n;
  logic          advance;
  logic [1:0]    wait_last;
  logic [IW-1:0] idx_last;

  assign pat_addr  = {is_test, label, idx};
  assign mlp_learn = (state == S_UPD);
  assign done      = (state == S_DONE);
  assign busy      = (state != S_IDLE) && (state != S_DONE);

  // Eval waits 2 cycles for mlp_OX to settle; training waits 3 so S1..S3 complete.
  assign wait_last = is_test ? 2'd1 : 2'd2;
  assign idx_last  = is_test ? IW'(NTEST - 1) : IW'(NTRAIN - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      is_test   <= 1'b0;
      label     <= 1'b0;
      idx       <= '0;
      wait_cnt  <= '0;
      phase     <= '0;
      epoch_cnt <= '0;
      pre_pass  <= '0;
      post_pass <= '0;
      mlp_x     <= '0;
      mlp_is_O  <= 1'b0;
    end else begin
      state     <= state_n;
      is_test   <= is_test_n;
      label     <= label_n;
      idx       <= idx_n;
      wait_cnt  <= wait_n;
      phase     <= phase_n;
      epoch_cnt <= epoch_n;
      pre_pass  <= pre_n;
      post_pass <= post_n;
      mlp_x     <= mlp_x_n;
      mlp_is_O  <= mlp_is_O_n;
    end
  end

  always_comb begin
    state_n    = state;
    is_test_n  = is_test;
    label_n    = label;
    idx_n      = idx;
    wait_n     = wait_cnt;
    phase_n    = phase;
    epoch_n    = epoch_cnt;
    pre_n      = pre_pass;
    post_n     = post_pass;
    mlp_x_n    = mlp_x;
    mlp_is_O_n = mlp_is_O;
    advance    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n   = S_FETCH;
          phase_n   = 2'd1;
          is_test_n = 1'b1;
          label_n   = 1'b1;
          idx_n     = '0;
          epoch_n   = '0;
          pre_n     = '0;
          post_n    = '0;
        end
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        mlp_x_n    = pat_data;
        mlp_is_O_n = label;
        wait_n     = '0;
        state_n    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == wait_last) state_n = is_test ? S_SAMPLE : S_UPD;
        else wait_n = wait_cnt + 2'd1;
      end
      S_SAMPLE: begin
        if (mlp_y == label) begin
          if (phase == 2'd1) pre_n = pre_pass + 8'd1;
          else post_n = post_pass + 8'd1;
        end
        advance = 1'b1;
      end
      S_UPD: state_n = S_GAP;
      S_GAP: advance = 1'b1;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Step to the next sample: O set, then X set, then the next pass or DONE.
    if (advance) begin
      state_n = S_FETCH;
      if (idx != idx_last) begin
        idx_n = idx + IW'(1);
      end else if (label) begin
        label_n = 1'b0;
        idx_n   = '0;
      end else begin
        label_n = 1'b1;
        idx_n   = '0;
        unique case (phase)
          2'd1: begin
            phase_n   = 2'd2;
            is_test_n = 1'b0;
          end
          2'd2: begin
            epoch_n = epoch_cnt + 8'd1;
            if (epoch_cnt + 8'd1 == 8'(EPOCHS)) begin
              phase_n   = 2'd3;
              is_test_n = 1'b1;
            end
          end
          default: begin
            phase_n = 2'd0;
            label_n = label;
            idx_n   = idx;
            state_n = S_DONE;
          end
        endcase
      end
    end
  end

endmodule
